// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE_CPU,
        DONE_AUX
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_AUX
    } owner_t;

    // Bits needed to count 0..max_streak inclusive.
    function automatic int streak_width(input int max_streak);
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Signal bundle around the arbiter: CPU M-stage port, aux requester port and
// the single data-memory port. master = arbiter side, slave = surroundings.
interface dmem_arbiter_if #(
    parameter int XLEN = 64
);
    // CPU (M stage)
    logic            CpuReq_M;
    logic            CpuWe_M;
    logic [XLEN-1:0] CpuAddr_M;
    logic [XLEN-1:0] CpuWData_M;
    logic            CpuStall_M;
    logic [XLEN-1:0] CpuRData_M;
    // Auxiliary requester (loader / debug)
    logic            AuxReq;
    logic            AuxWe;
    logic [XLEN-1:0] AuxAddr;
    logic [XLEN-1:0] AuxWData;
    logic            AuxGnt;
    logic            AuxRValid;
    logic [XLEN-1:0] AuxRData;
    // Data memory
    logic            MemReq;
    logic            MemWe;
    logic [XLEN-1:0] MemAddr;
    logic [XLEN-1:0] MemWData;
    logic            MemGnt;
    logic            MemRValid;
    logic [XLEN-1:0] MemRData;

    modport master (
        input  CpuReq_M, CpuWe_M, CpuAddr_M, CpuWData_M,
        output CpuStall_M, CpuRData_M,
        input  AuxReq, AuxWe, AuxAddr, AuxWData,
        output AuxGnt, AuxRValid, AuxRData,
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemGnt, MemRValid, MemRData
    );

    modport slave (
        output CpuReq_M, CpuWe_M, CpuAddr_M, CpuWData_M,
        input  CpuStall_M, CpuRData_M,
        output AuxReq, AuxWe, AuxAddr, AuxWData,
        input  AuxGnt, AuxRValid, AuxRData,
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemGnt, MemRValid, MemRData
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for the M stage: shares one memory port between the
// pipeline and an auxiliary requester, one outstanding transaction at a time.
// The pipeline is stalled for the whole life of a CPU access.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.master bus
);

    localparam int                  STREAK_W   = streak_width(MAX_CPU_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

    arb_state_t          state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_we_q,    mem_we_d;
    logic [XLEN-1:0]     mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [XLEN-1:0]     aux_rdata_q, aux_rdata_d;

    logic cpu_win;
    logic aux_win;
    logic mem_req;

    // Arbitration decision; only acted upon in IDLE. Aux takes the port once
    // the CPU has used up its streak allowance while Aux was waiting.
    always_comb begin
        cpu_win = 1'b0;
        aux_win = 1'b0;
        if (bus.AuxReq && (!bus.CpuReq_M || (streak_q >= STREAK_MAX))) begin
            aux_win = 1'b1;
        end else if (bus.CpuReq_M) begin
            cpu_win = 1'b1;
        end
    end

    // Next-state and datapath-next logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;

        case (state_q)
            IDLE: begin
                if (aux_win) begin
                    state_d     = REQ;
                    owner_d     = OWN_AUX;
                    mem_we_d    = bus.AuxWe;
                    mem_addr_d  = bus.AuxAddr;
                    mem_wdata_d = bus.AuxWData;
                end else if (cpu_win) begin
                    state_d     = REQ;
                    owner_d     = OWN_CPU;
                    mem_we_d    = bus.CpuWe_M;
                    mem_addr_d  = bus.CpuAddr_M;
                    mem_wdata_d = bus.CpuWData_M;
                end
                // Streak only counts CPU grants that made a waiting Aux wait longer.
                if (aux_win || !bus.AuxReq) begin
                    streak_d = '0;
                end else if (cpu_win && (streak_q != STREAK_MAX)) begin
                    streak_d = streak_q + 1'b1;
                end
            end
            REQ: begin
                if (bus.MemGnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.MemRValid) begin
                    // Stores return no data, so the read-data registers keep their value.
                    if (owner_q == OWN_CPU) begin
                        state_d = DONE_CPU;
                        if (!mem_we_q) begin
                            cpu_rdata_d = bus.MemRData;
                        end
                    end else begin
                        state_d = DONE_AUX;
                        if (!mem_we_q) begin
                            aux_rdata_d = bus.MemRData;
                        end
                    end
                end
            end
            DONE_CPU: state_d = IDLE;
            DONE_AUX: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, owner, streak and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    assign mem_req = (state_q == REQ);

    // The pipeline is released for exactly the completion cycle of its access.
    assign bus.CpuStall_M = bus.CpuReq_M && (state_q != DONE_CPU);
    assign bus.CpuRData_M = cpu_rdata_q;

    // Grant is suppressed during reset so nothing is reported as captured.
    assign bus.AuxGnt    = !rst && (state_q == IDLE) && aux_win;
    assign bus.AuxRValid = (state_q == DONE_AUX);
    assign bus.AuxRData  = aux_rdata_q;

    assign bus.MemReq   = mem_req;
    assign bus.MemWe    = mem_req && mem_we_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWData = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-timeline model predicts
// every output each cycle; directed scenarios pin the model with literals,
// then a randomized phase with random memory delays and resets follows.
module tb_dmem_arbiter;

    localparam int XLEN = 64;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if #(.XLEN(XLEN)) bus ();

    dmem_arbiter #(.XLEN(XLEN), .MAX_CPU_STREAK(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: at most one transaction, described by when it was granted and
    // how long the memory takes to accept and to complete it.
    bit              m_busy   = 0;
    bit              m_aux    = 0;
    bit              m_we     = 0;
    logic [XLEN-1:0] m_addr, m_wdata, m_rdata;
    int              m_t0     = 0;
    int              m_gd     = 0;
    int              m_rd     = 0;
    int              m_streak = 0;
    int              cyc      = 0;

    int              f_gd = -1;
    int              f_rd = -1;
    bit              f_rdata_en = 0;
    logic [XLEN-1:0] f_rdata = '0;

    bit ev_cpu_done = 0;
    bit ev_aux_gnt  = 0;

    bit cpu_pend = 0;
    bit aux_pend = 0;
    int p_cpu = 0;
    int p_aux = 0;

    logic            s_stall, s_memreq, s_memwe, s_auxgnt, s_auxrv;
    logic [XLEN-1:0] s_addr, s_wdata, s_cpu_rdata, s_aux_rdata;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sample();
        s_stall     = bus.CpuStall_M;
        s_memreq    = bus.MemReq;
        s_memwe     = bus.MemWe;
        s_auxgnt    = bus.AuxGnt;
        s_auxrv     = bus.AuxRValid;
        s_addr      = bus.MemAddr;
        s_wdata     = bus.MemWData;
        s_cpu_rdata = bus.CpuRData_M;
        s_aux_rdata = bus.AuxRData;
    endtask

    // Memory responder follows the model's planned timeline for the transaction.
    task automatic drive_mem();
        int k;
        bus.MemGnt    = 1'b0;
        bus.MemRValid = 1'b0;
        bus.MemRData  = {$urandom(), $urandom()};
        if (!rst && m_busy) begin
            k = cyc - m_t0;
            if (k == 1 + m_gd) bus.MemGnt = 1'b1;
            if (k == 2 + m_gd + m_rd) begin
                bus.MemRValid = 1'b1;
                bus.MemRData  = m_rdata;
            end
        end
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model.
    task automatic check_cycle();
        logic e_stall, e_memreq, e_auxgnt, e_auxrv;
        bit   cpu_w, aux_w, rd_cpu, rd_aux, in_rst;
        int   k;
        e_stall  = bus.CpuReq_M;
        e_memreq = 1'b0;
        e_auxgnt = 1'b0;
        e_auxrv  = 1'b0;
        rd_cpu   = 0;
        rd_aux   = 0;
        in_rst   = rst;
        ev_cpu_done = 0;
        ev_aux_gnt  = 0;
        sample();
        if (rst) begin
            m_busy   = 0;
            m_streak = 0;
        end else if (!m_busy) begin
            cpu_w = bus.CpuReq_M && !(bus.AuxReq && (m_streak >= MAXS));
            aux_w = bus.AuxReq && !cpu_w;
            e_auxgnt   = aux_w;
            ev_aux_gnt = aux_w;
            if (cpu_w || aux_w) begin
                m_busy  = 1;
                m_aux   = aux_w;
                m_we    = aux_w ? bus.AuxWe    : bus.CpuWe_M;
                m_addr  = aux_w ? bus.AuxAddr  : bus.CpuAddr_M;
                m_wdata = aux_w ? bus.AuxWData : bus.CpuWData_M;
                m_t0    = cyc;
                m_gd    = (f_gd >= 0) ? f_gd : int'($urandom_range(0, 3));
                m_rd    = (f_rd >= 0) ? f_rd : int'($urandom_range(0, 3));
                m_rdata = f_rdata_en ? f_rdata : {$urandom(), $urandom()};
            end
            if (aux_w || !bus.AuxReq) m_streak = 0;
            else                       m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        end else begin
            k = cyc - m_t0;
            if (k <= 1 + m_gd) e_memreq = 1'b1;
            if (k == 3 + m_gd + m_rd) begin
                if (m_aux) begin
                    e_auxrv = 1'b1;
                    rd_aux  = !m_we;
                end else begin
                    e_stall     = 1'b0;
                    ev_cpu_done = 1;
                    rd_cpu      = !m_we;
                end
                m_busy = 0;
            end
        end
        chk("CpuStall_M", s_stall,  e_stall);
        chk("MemReq",     s_memreq, e_memreq);
        chk("MemWe",      s_memwe,  e_memreq && m_we);
        chk("AuxGnt",     s_auxgnt, e_auxgnt);
        chk("AuxRValid",  s_auxrv,  e_auxrv);
        if (e_memreq) begin
            chk("MemAddr",  s_addr,  m_addr);
            chk("MemWData", s_wdata, m_wdata);
        end
        if (rd_cpu) chk("CpuRData_M", s_cpu_rdata, m_rdata);
        if (rd_aux) chk("AuxRData",   s_aux_rdata, m_rdata);
        if (in_rst) begin
            chk("rst_MemAddr",    s_addr,      '0);
            chk("rst_MemWData",   s_wdata,     '0);
            chk("rst_CpuRData_M", s_cpu_rdata, '0);
            chk("rst_AuxRData",   s_aux_rdata, '0);
        end
        cyc++;
    endtask

    // One clock cycle: entered and left just after a rising edge.
    task automatic step();
        drive_mem();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // Randomized requesters: a CPU request is held until its completion cycle,
    // an aux request until its grant; afterwards each may be replaced or dropped.
    task automatic drive_reqs();
        if (cpu_pend && ev_cpu_done) cpu_pend = 0;
        if (!cpu_pend) begin
            if (int'($urandom_range(0, 99)) < p_cpu) begin
                cpu_pend       = 1;
                bus.CpuReq_M   = 1'b1;
                bus.CpuWe_M    = 1'($urandom_range(0, 1));
                bus.CpuAddr_M  = {$urandom(), $urandom()};
                bus.CpuWData_M = {$urandom(), $urandom()};
            end else begin
                bus.CpuReq_M = 1'b0;
            end
        end
        if (aux_pend && ev_aux_gnt) aux_pend = 0;
        if (!aux_pend) begin
            if (int'($urandom_range(0, 99)) < p_aux) begin
                aux_pend     = 1;
                bus.AuxReq   = 1'b1;
                bus.AuxWe    = 1'($urandom_range(0, 1));
                bus.AuxAddr  = {$urandom(), $urandom()};
                bus.AuxWData = {$urandom(), $urandom()};
            end else begin
                bus.AuxReq = 1'b0;
            end
        end
    endtask

    initial begin
        int    cnt;
        int    cnt2;
        int    gnt_at;
        bit    ok;
        string order;
        logic  prev_memreq;
        logic  prev_auxgnt;

        rst            = 1'b1;
        bus.CpuReq_M   = 1'b0;
        bus.CpuWe_M    = 1'b0;
        bus.CpuAddr_M  = '0;
        bus.CpuWData_M = '0;
        bus.AuxReq     = 1'b0;
        bus.AuxWe      = 1'b0;
        bus.AuxAddr    = '0;
        bus.AuxWData   = '0;
        bus.MemGnt     = 1'b0;
        bus.MemRValid  = 1'b0;
        bus.MemRData   = '0;

        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_state_MemReq",    s_memreq, 1'b0);
        chk("rst_state_AuxRValid", s_auxrv,  1'b0);
        rst = 1'b0;

        // CPU load, memory answers as fast as possible.
        f_gd = 0; f_rd = 0; f_rdata_en = 1; f_rdata = 64'hDEAD;
        bus.CpuReq_M = 1'b1; bus.CpuWe_M = 1'b0; bus.CpuAddr_M = 64'h100; bus.CpuWData_M = '0;
        cnt = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_stall === 1'b1) cnt++;
            else begin ok = 1; break; end
        end
        chk("t1_done", ok, 1);
        chk("t1_stall_cycles", cnt, 3);
        chk("t1_rdata", s_cpu_rdata, 64'hDEAD);
        bus.CpuReq_M = 1'b0;

        // CPU store with a grant delayed by two cycles.
        f_gd = 2; f_rd = 0;
        bus.CpuReq_M = 1'b1; bus.CpuWe_M = 1'b1; bus.CpuAddr_M = 64'h80; bus.CpuWData_M = 64'h55;
        cnt = 0; cnt2 = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_memreq === 1'b1 && s_memwe === 1'b1 && s_addr === 64'h80 && s_wdata === 64'h55) cnt2++;
            if (s_stall === 1'b1) cnt++;
            else begin ok = 1; break; end
        end
        chk("t2_done", ok, 1);
        chk("t2_stall_cycles", cnt, 5);
        chk("t2_memreq_cycles", cnt2, 3);
        bus.CpuReq_M = 1'b0;

        // Aux read alone.
        f_gd = 0; f_rd = 0; f_rdata = 64'h1234;
        bus.AuxReq = 1'b1; bus.AuxWe = 1'b0; bus.AuxAddr = 64'h200; bus.AuxWData = '0;
        cnt = 0; cnt2 = 0; ok = 0; gnt_at = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_stall !== 1'b0) cnt2++;
            if (s_auxgnt === 1'b1) begin
                cnt++;
                gnt_at = i;
                bus.AuxReq = 1'b0;
            end
            if (s_auxrv === 1'b1) begin ok = 1; break; end
        end
        chk("t4_done", ok, 1);
        chk("t4_gnt_pulses", cnt, 1);
        chk("t4_gnt_at_idle", gnt_at, 0);
        chk("t4_cpu_stall_cycles", cnt2, 0);
        chk("t4_rdata", s_aux_rdata, 64'h1234);

        // CPU request appears while the aux access is completing.
        f_rdata = 64'h5A5A;
        bus.AuxReq = 1'b1; bus.AuxWe = 1'b0; bus.AuxAddr = 64'h300;
        step();
        chk("t6_auxgnt", s_auxgnt, 1'b1);
        bus.AuxReq = 1'b0;
        f_rdata = 64'h777;
        step();
        step();
        bus.CpuReq_M = 1'b1; bus.CpuWe_M = 1'b0; bus.CpuAddr_M = 64'h140;
        step();
        chk("t6_auxrvalid", s_auxrv, 1'b1);
        chk("t6_aux_rdata", s_aux_rdata, 64'h5A5A);
        chk("t6_no_memreq_in_done", s_memreq, 1'b0);
        chk("t6_stall_in_done_aux", s_stall, 1'b1);
        cnt = 1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_stall === 1'b1) cnt++;
            else begin ok = 1; break; end
        end
        chk("t6_done", ok, 1);
        chk("t6_stall_cycles", cnt, 4);
        chk("t6_rdata", s_cpu_rdata, 64'h777);
        bus.CpuReq_M = 1'b0;

        // Reset while waiting for read data, then a clean load.
        f_gd = 0; f_rd = 3; f_rdata = 64'hBAD;
        bus.CpuReq_M = 1'b1; bus.CpuWe_M = 1'b0; bus.CpuAddr_M = 64'h180;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("t5_memreq_in_rst", s_memreq, 1'b0);
        chk("t5_auxrvalid_in_rst", s_auxrv, 1'b0);
        chk("t5_stall_in_rst", s_stall, 1'b1);
        step();
        rst = 1'b0;
        f_rd = 0; f_rdata = 64'hBEEF;
        cnt = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_stall === 1'b1) cnt++;
            else begin ok = 1; break; end
        end
        chk("t5_done", ok, 1);
        chk("t5_stall_cycles", cnt, 3);
        chk("t5_rdata", s_cpu_rdata, 64'hBEEF);
        bus.CpuReq_M = 1'b0;

        // Both requesters continuously busy: CPU streak then one aux grant.
        f_gd = 0; f_rd = 0; f_rdata_en = 0;
        p_cpu = 100; p_aux = 100; cpu_pend = 0; aux_pend = 0;
        order = ""; prev_memreq = 1'b0; prev_auxgnt = 1'b0; cnt = 0;
        for (int i = 0; i < 100 && order.len() < 6; i++) begin
            drive_reqs();
            step();
            if (s_auxgnt === 1'b1) cnt++;
            if (s_memreq === 1'b1 && prev_memreq !== 1'b1) begin
                if (prev_auxgnt === 1'b1) order = {order, "A"};
                else                      order = {order, "C"};
            end
            prev_memreq = s_memreq;
            prev_auxgnt = s_auxgnt;
        end
        n_tests++;
        if (order != "CCCCAC") begin
            n_fail++;
            $display("FAIL t3_grant_order: got %s, expected CCCCAC", order);
        end
        chk("t3_auxgnt_pulses", cnt, 1);

        // Random traffic with random memory latency and occasional resets.
        f_gd = -1; f_rd = -1;
        p_cpu = 35; p_aux = 25;
        for (int i = 0; i < 4000; i++) begin
            if (rst) rst = 1'b0;
            else     rst = ($urandom_range(0, 299) == 0);
            drive_reqs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
